stream_mux: RTL

- Parametrised successor to the 2:1 combinational mux: NUM_IN input streams of WIDTH bits, each with a valid/ready handshake, merged onto one registered output stream.
- Two selection modes, chosen at runtime:
  - static select: the source is picked by sel.
  - round-robin: fair arbitration across requesters.
- Sits between producer channels and a shared downstream consumer (bus, FIFO, serializer).

---
 rtl/stream_mux_pkg.sv | 15 +
 rtl/stream_mux_if.sv | 43 ++++
 rtl/stream_mux_rr_arbiter.sv | 34 +++
 rtl/stream_mux.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux block.
// Used by the top-level mux and by its round-robin arbiter.
package stream_mux_pkg;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_RR     = 1'b1
  } mux_mode_e;

  // Index that follows ptr in a ring of n channels.
  function automatic int next_ptr(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Handshake bundle between NUM_IN producers, the stream_mux and one consumer.
// The last-beat signals exist only when STREAM_MUX_LOCK_EN is defined.
interface stream_mux_if #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 8
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
`ifdef STREAM_MUX_LOCK_EN
  logic [NUM_IN-1:0]       in_last;
  logic                    out_last;

  modport master (
    output mode, sel, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_src, out_last
  );

  modport slave (
    input  mode, sel, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_src, out_last
  );
`else
  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
`endif

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// The pointer register is owned by the instantiating module.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    int idx;
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held and no latch is inferred.
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = int'(ptr);
    for (int k = 0; k < N; k++) begin
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = IDX_W'(idx);
        gnt[idx] = 1'b1;
      end
      idx = next_ptr(idx, N);
    end
  end

endmodule

// File: rtl/stream_mux.sv
// NUM_IN-to-1 valid/ready stream mux with static or round-robin selection and
// a single output register. Define STREAM_MUX_LOCK_EN for packet (last) locking.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter  int NUM_IN = 4,
  parameter  int WIDTH  = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic         clk,
  input  logic         rst,
  stream_mux_if.slave  bus
);

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_src_q,   out_src_d;
  logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;
`ifdef STREAM_MUX_LOCK_EN
  logic              lock_q,      lock_d;
  logic [SEL_W-1:0]  lock_idx_q,  lock_idx_d;
  logic              out_last_q,  out_last_d;
`endif

  mux_mode_e         mode;
  logic              sel_ok;
  logic [NUM_IN-1:0] rr_gnt;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_any;
  logic              can_load;
  logic              xfer;

  assign mode   = mux_mode_e'(bus.mode);
  assign sel_ok = ({1'b0, bus.sel} < NUM_IN_W);

  rr_arbiter #(.N(NUM_IN)) u_rr_arbiter (
    .req     (bus.in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Pick at most one channel; a held lock overrides both mode and sel.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
    if (lock_q) begin
      grant_idx = lock_idx_q;
      grant_any = bus.in_valid[lock_idx_q];
    end else
`endif
    if (mode == MODE_RR) begin
      grant_idx = rr_idx;
      grant_any = rr_any;
    end else if (sel_ok) begin
      grant_idx = bus.sel;
      grant_any = bus.in_valid[bus.sel];
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign can_load     = !out_valid_q || bus.out_ready;
  assign xfer         = grant_any && can_load;
  assign bus.in_ready = (rst || !can_load) ? '0 : grant;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef STREAM_MUX_LOCK_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_src_d   = grant_idx;
`ifdef STREAM_MUX_LOCK_EN
      out_last_d  = bus.in_last[grant_idx];
      lock_d      = !bus.in_last[grant_idx];
      lock_idx_d  = grant_idx;
      // The pointer only moves past a channel once its packet has ended.
      if (mode == MODE_RR && bus.in_last[grant_idx]) begin
        rr_ptr_d = SEL_W'(next_ptr(int'(grant_idx), NUM_IN));
      end
`else
      if (mode == MODE_RR) begin
        rr_ptr_d = SEL_W'(next_ptr(int'(grant_idx), NUM_IN));
      end
`endif
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
`ifdef STREAM_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
`ifdef STREAM_MUX_LOCK_EN
  assign bus.out_last  = out_last_q;
`endif

endmodule
